btn_conditioner: RTL and testbench

BTN_CONDITIONER -- requirements
Module: btn_conditioner

---
 rtl/btn_conditioner.sv | 152 +++++++++++++++
 tb/tb_btn_conditioner.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
// Multi-channel push-button conditioner: 2-flop synchronizer, debounce filter,
// registered press/release pulses and optional auto-repeat per channel.
module btn_conditioner #(
    parameter int N_CH       = 4,
    parameter int DB_CYCLES  = 50000,
    parameter int ACT_LOW    = 1,
    parameter int REP_EN     = 0,
    parameter int REP_DELAY  = 25000000,
    parameter int REP_PERIOD = 5000000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] btn_raw,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] press,
    // "release" and "repeat" are SystemVerilog keywords, hence the suffix.
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] repeat_pulse
);

    typedef enum logic [1:0] {
        IDLE,
        HOLD_DELAY,
        HOLD_REPEAT
    } rep_state_t;

    localparam int   DB_W     = $clog2(DB_CYCLES + 1);
    localparam logic RAW_IDLE = (ACT_LOW != 0);

    if (N_CH < 1 || N_CH > 16) begin : g_bad_n_ch
        $error("btn_conditioner: N_CH must be 1..16");
    end
    if (DB_CYCLES < 1 || DB_CYCLES > (1 << 20)) begin : g_bad_db
        $error("btn_conditioner: DB_CYCLES must be 1..2^20");
    end
    if (REP_DELAY < 1 || REP_DELAY > (1 << 26) ||
        REP_PERIOD < 1 || REP_PERIOD > (1 << 26)) begin : g_bad_rep
        $error("btn_conditioner: REP_DELAY/REP_PERIOD must be 1..2^26");
    end

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        logic [1:0]      sync_q;
        logic            sample;
        logic [DB_W-1:0] db_cnt_q;
        logic            level_q;
        logic            press_q;
        logic            release_q;
        logic            db_done;

        assign sample  = (ACT_LOW != 0) ? ~sync_q[1] : sync_q[1];
        // The counter only runs while the sample disagrees with level, so
        // reaching the terminal count is exactly the moment level flips.
        assign db_done = (sample != level_q) &&
                         (db_cnt_q == DB_W'(DB_CYCLES - 1));

        // NOTE: non-blocking assignments make every flop here sample the
        // pre-edge values, so the synchronizer really is two stages deep.
        always_ff @(posedge clk) begin
            if (reset) begin
                sync_q    <= {2{RAW_IDLE}};
                db_cnt_q  <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                sync_q    <= {sync_q[0], btn_raw[ch]};
                press_q   <= db_done & ~level_q;
                release_q <= db_done &  level_q;
                if (sample == level_q) begin
                    db_cnt_q <= '0;
                end else if (db_done) begin
                    db_cnt_q <= '0;
                    level_q  <= ~level_q;
                end else begin
                    db_cnt_q <= db_cnt_q + DB_W'(1);
                end
            end
        end

        assign level[ch]         = level_q;
        assign press[ch]         = press_q;
        assign release_pulse[ch] = release_q;

        if (REP_EN != 0) begin : g_rep
            localparam int REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
            localparam int REP_W   = $clog2(REP_MAX + 1);

            rep_state_t       state_q;
            rep_state_t       state_d;
            logic [REP_W-1:0] rep_cnt_q;
            logic [REP_W-1:0] rep_cnt_d;
            logic             fire;
            logic             fall_now;

            // Leaving on the debounced fall (not the registered release) keeps
            // the FSM idle during the release pulse cycle.
            assign fall_now = db_done & level_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    state_q   <= IDLE;
                    rep_cnt_q <= '0;
                end else begin
                    state_q   <= state_d;
                    rep_cnt_q <= rep_cnt_d;
                end
            end

            // NOTE: every output of this block gets a default first, so no
            // path through the case can infer a latch.
            always_comb begin
                state_d   = state_q;
                rep_cnt_d = rep_cnt_q + REP_W'(1);
                fire      = 1'b0;
                case (state_q)
                    IDLE: begin
                        rep_cnt_d = '0;
                        if (press_q) begin
                            state_d = HOLD_DELAY;
                        end
                    end
                    HOLD_DELAY: begin
                        if (rep_cnt_q == REP_W'(REP_DELAY - 1)) begin
                            fire      = 1'b1;
                            state_d   = HOLD_REPEAT;
                            rep_cnt_d = '0;
                        end
                    end
                    HOLD_REPEAT: begin
                        if (rep_cnt_q == REP_W'(REP_PERIOD - 1)) begin
                            fire      = 1'b1;
                            rep_cnt_d = '0;
                        end
                    end
                    default: begin
                        state_d   = IDLE;
                        rep_cnt_d = '0;
                    end
                endcase
                if (fall_now) begin
                    state_d   = IDLE;
                    rep_cnt_d = '0;
                end
            end

            assign repeat_pulse[ch] = fire;
        end else begin : g_no_rep
            assign repeat_pulse[ch] = 1'b0;
        end
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Table-driven bench for btn_conditioner: run-length vectors of inputs and
// expected outputs, plus a bounded press-latency measurement.
module tb_btn_conditioner;

    localparam int N_CH = 2;

    logic            clk;
    logic            reset;
    logic [N_CH-1:0] btn_raw;
    logic [N_CH-1:0] level;
    logic [N_CH-1:0] press;
    logic [N_CH-1:0] release_pulse;
    logic [N_CH-1:0] repeat_pulse;

    btn_conditioner #(
        .N_CH       (N_CH),
        .DB_CYCLES  (4),
        .ACT_LOW    (1),
        .REP_EN     (1),
        .REP_DELAY  (10),
        .REP_PERIOD (3)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_raw       (btn_raw),
        .level         (level),
        .press         (press),
        .release_pulse (release_pulse),
        .repeat_pulse  (repeat_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One record = hold these inputs for n edges; after each edge the outputs
    // must equal the expected values.
    typedef struct {
        logic       rst;
        logic [1:0] raw;
        int         n;
        logic [1:0] lvl;
        logic [1:0] prs;
        logic [1:0] rel;
        logic [1:0] rpt;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function void add(input logic rst, input logic [1:0] raw, input int n,
                      input logic [1:0] lvl, input logic [1:0] prs,
                      input logic [1:0] rel, input logic [1:0] rpt);
        vecs.push_back('{rst, raw, n, lvl, prs, rel, rpt});
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic rst, input logic [1:0] raw);
        reset   = rst;
        btn_raw = raw;
        @(posedge clk);
        #1;
    endtask

    int waited;

    initial begin
        reset   = 1'b1;
        btn_raw = 2'b11;

        // Reset state, then idle.
        add(1, 2'b11, 2, 2'b00, 2'b00, 2'b00, 2'b00);
        add(0, 2'b11, 3, 2'b00, 2'b00, 2'b00, 2'b00);

        // Channel 0 press, repeats at +10/+13/+16, release blocks the +19 repeat.
        add(0, 2'b10, 5, 2'b00, 2'b00, 2'b00, 2'b00);
        add(0, 2'b10, 1, 2'b01, 2'b01, 2'b00, 2'b00);
        add(0, 2'b10, 9, 2'b01, 2'b00, 2'b00, 2'b00);
        add(0, 2'b10, 1, 2'b01, 2'b00, 2'b00, 2'b01);
        add(0, 2'b10, 2, 2'b01, 2'b00, 2'b00, 2'b00);
        add(0, 2'b10, 1, 2'b01, 2'b00, 2'b00, 2'b01);
        add(0, 2'b11, 2, 2'b01, 2'b00, 2'b00, 2'b00);
        add(0, 2'b11, 1, 2'b01, 2'b00, 2'b00, 2'b01);
        add(0, 2'b11, 2, 2'b01, 2'b00, 2'b00, 2'b00);
        add(0, 2'b11, 1, 2'b00, 2'b00, 2'b01, 2'b00);
        add(0, 2'b11, 4, 2'b00, 2'b00, 2'b00, 2'b00);

        // Longest rejected glitch (3 samples), then the shortest accepted (4).
        add(0, 2'b10, 3, 2'b00, 2'b00, 2'b00, 2'b00);
        add(0, 2'b11, 6, 2'b00, 2'b00, 2'b00, 2'b00);
        add(0, 2'b10, 4, 2'b00, 2'b00, 2'b00, 2'b00);
        add(0, 2'b11, 1, 2'b00, 2'b00, 2'b00, 2'b00);
        add(0, 2'b11, 1, 2'b01, 2'b01, 2'b00, 2'b00);
        add(0, 2'b11, 3, 2'b01, 2'b00, 2'b00, 2'b00);
        add(0, 2'b11, 1, 2'b00, 2'b00, 2'b01, 2'b00);
        add(0, 2'b11, 3, 2'b00, 2'b00, 2'b00, 2'b00);

        // Channel 1 held low for 40 cycles.
        add(0, 2'b01, 5, 2'b00, 2'b00, 2'b00, 2'b00);
        add(0, 2'b01, 1, 2'b10, 2'b10, 2'b00, 2'b00);
        add(0, 2'b01, 9, 2'b10, 2'b00, 2'b00, 2'b00);
        for (int k = 0; k < 8; k++) begin
            add(0, 2'b01, 1, 2'b10, 2'b00, 2'b00, 2'b10);
            add(0, 2'b01, 2, 2'b10, 2'b00, 2'b00, 2'b00);
        end
        add(0, 2'b01, 1, 2'b10, 2'b00, 2'b00, 2'b10);
        add(0, 2'b11, 2, 2'b10, 2'b00, 2'b00, 2'b00);
        add(0, 2'b11, 1, 2'b10, 2'b00, 2'b00, 2'b10);
        add(0, 2'b11, 2, 2'b10, 2'b00, 2'b00, 2'b00);
        add(0, 2'b11, 1, 2'b00, 2'b00, 2'b10, 2'b00);
        add(0, 2'b11, 4, 2'b00, 2'b00, 2'b00, 2'b00);

        // Both channels pressed together; channel 0 released first.
        add(0, 2'b00, 5, 2'b00, 2'b00, 2'b00, 2'b00);
        add(0, 2'b00, 1, 2'b11, 2'b11, 2'b00, 2'b00);
        add(0, 2'b00, 9, 2'b11, 2'b00, 2'b00, 2'b00);
        add(0, 2'b00, 1, 2'b11, 2'b00, 2'b00, 2'b11);
        add(0, 2'b00, 2, 2'b11, 2'b00, 2'b00, 2'b00);
        add(0, 2'b00, 1, 2'b11, 2'b00, 2'b00, 2'b11);
        add(0, 2'b01, 2, 2'b11, 2'b00, 2'b00, 2'b00);
        add(0, 2'b01, 1, 2'b11, 2'b00, 2'b00, 2'b11);
        add(0, 2'b01, 2, 2'b11, 2'b00, 2'b00, 2'b00);
        add(0, 2'b01, 1, 2'b10, 2'b00, 2'b01, 2'b10);
        add(0, 2'b01, 2, 2'b10, 2'b00, 2'b00, 2'b00);
        add(0, 2'b01, 1, 2'b10, 2'b00, 2'b00, 2'b10);
        add(0, 2'b11, 2, 2'b10, 2'b00, 2'b00, 2'b00);
        add(0, 2'b11, 1, 2'b10, 2'b00, 2'b00, 2'b10);
        add(0, 2'b11, 2, 2'b10, 2'b00, 2'b00, 2'b00);
        add(0, 2'b11, 1, 2'b00, 2'b00, 2'b10, 2'b00);
        add(0, 2'b11, 4, 2'b00, 2'b00, 2'b00, 2'b00);

        // Reset mid-repeat with channel 0 held: no release, fresh press 6 later.
        add(0, 2'b10, 5, 2'b00, 2'b00, 2'b00, 2'b00);
        add(0, 2'b10, 1, 2'b01, 2'b01, 2'b00, 2'b00);
        add(0, 2'b10, 9, 2'b01, 2'b00, 2'b00, 2'b00);
        add(0, 2'b10, 1, 2'b01, 2'b00, 2'b00, 2'b01);
        add(0, 2'b10, 2, 2'b01, 2'b00, 2'b00, 2'b00);
        add(0, 2'b10, 1, 2'b01, 2'b00, 2'b00, 2'b01);
        add(0, 2'b10, 1, 2'b01, 2'b00, 2'b00, 2'b00);
        add(1, 2'b10, 1, 2'b00, 2'b00, 2'b00, 2'b00);
        add(0, 2'b10, 5, 2'b00, 2'b00, 2'b00, 2'b00);
        add(0, 2'b10, 1, 2'b01, 2'b01, 2'b00, 2'b00);
        add(0, 2'b10, 9, 2'b01, 2'b00, 2'b00, 2'b00);
        add(0, 2'b10, 1, 2'b01, 2'b00, 2'b00, 2'b01);

        // Reset with the debounce counter at 2 discards the progress.
        add(1, 2'b11, 1, 2'b00, 2'b00, 2'b00, 2'b00);
        add(0, 2'b11, 3, 2'b00, 2'b00, 2'b00, 2'b00);
        add(0, 2'b10, 4, 2'b00, 2'b00, 2'b00, 2'b00);
        add(1, 2'b10, 1, 2'b00, 2'b00, 2'b00, 2'b00);
        add(0, 2'b10, 5, 2'b00, 2'b00, 2'b00, 2'b00);
        add(0, 2'b10, 1, 2'b01, 2'b01, 2'b00, 2'b00);
        add(0, 2'b10, 2, 2'b01, 2'b00, 2'b00, 2'b00);

        for (int i = 0; i < vecs.size(); i++) begin
            for (int j = 0; j < vecs[i].n; j++) begin
                step(vecs[i].rst, vecs[i].raw);
                check($sformatf("level v%0d.%0d", i, j), 32'(level), 32'(vecs[i].lvl));
                check($sformatf("press v%0d.%0d", i, j), 32'(press), 32'(vecs[i].prs));
                check($sformatf("release v%0d.%0d", i, j), 32'(release_pulse), 32'(vecs[i].rel));
                check($sformatf("repeat v%0d.%0d", i, j), 32'(repeat_pulse), 32'(vecs[i].rpt));
                check($sformatf("exclusive v%0d.%0d", i, j),
                      32'((press & release_pulse) | (press & repeat_pulse) |
                          (release_pulse & repeat_pulse)), 32'd0);
            end
        end

        // Measured press latency on channel 1, bounded by a cycle budget.
        step(1'b1, 2'b11);
        for (int k = 0; k < 3; k++) step(1'b0, 2'b11);
        waited = 0;
        do begin
            step(1'b0, 2'b01);
            waited++;
        end while (press[1] !== 1'b1 && waited < 20);
        check("press latency", 32'(waited), 32'd6);
        check("latency level", 32'(level), 32'h2);
        step(1'b0, 2'b01);
        check("press width", 32'(press), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
